// File: rtl/meas_frame_packer.sv
// meas_frame_packer
//   Packs a snapshot of NUM_CH measurement words into a byte-serial frame:
//   HDR0, HDR1, SEQ, payload (ch0 first, each word MSB byte first), CHK.
//   CHK is the mod-256 sum of SEQ and the payload bytes.
//   Byte output uses a valid/ready handshake.
//
// Ports
//   sys_clk    : clock, rising edge
//   rst_n      : synchronous active-low reset
//   ch_data    : concatenated channel words, ch0 in the MSBs
//   frame_req  : frame start request, sampled only while idle
//   auto_mode  : restart frames back-to-back without a request
//   byte_ready : downstream accepts byte_data
//   byte_data  : current frame byte (8'h00 while idle)
//   byte_valid : byte_data is valid
//   frame_busy : a frame is in progress
//   frame_done : one-cycle pulse after the checksum byte transfers
//   seq_cnt    : sequence number of the next frame to be sent
module meas_frame_packer #(
    parameter int unsigned NUM_CH     = 5,
    parameter int unsigned WORD_BYTES = 4,
    parameter logic [7:0]  HDR0       = 8'h55,
    parameter logic [7:0]  HDR1       = 8'hAA
) (
    input  logic                           sys_clk,
    input  logic                           rst_n,
    input  logic [NUM_CH*WORD_BYTES*8-1:0] ch_data,
    input  logic                           frame_req,
    input  logic                           auto_mode,
    input  logic                           byte_ready,
    output logic [7:0]                     byte_data,
    output logic                           byte_valid,
    output logic                           frame_busy,
    output logic                           frame_done,
    output logic [7:0]                     seq_cnt
);

    localparam int unsigned PAY_BYTES = NUM_CH * WORD_BYTES;
    localparam int unsigned IDX_W     = 7;
    // Frame byte index: 0=HDR0, 1=HDR1, 2=SEQ, 3..PAY_BYTES+2 = payload.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAY_BYTES + 2);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        CSUM
    } state_t;

    state_t                    state;
    logic [PAY_BYTES*8-1:0]    shadow;
    logic [7:0]                seq_frame;
    logic [IDX_W-1:0]          idx;
    logic [7:0]                chk_acc;

    logic [IDX_W-1:0]          idx_inc;
    logic [7:0]                next_byte;
    logic [7:0]                chk_next;

    // byte_data always holds the byte at idx, so the sum is taken from the
    // output register as each byte leaves; headers (idx 0/1) are skipped.
    always_comb begin
        idx_inc   = idx + IDX_W'(1);
        chk_next  = (idx >= IDX_W'(2)) ? chk_acc + byte_data : chk_acc;
        next_byte = '0;
        if (idx_inc == IDX_W'(1)) begin
            next_byte = HDR1;
        end else if (idx_inc == IDX_W'(2)) begin
            next_byte = seq_frame;
        end else begin
            for (int unsigned i = 0; i < PAY_BYTES; i++) begin
                if (idx_inc == IDX_W'(i + 3)) begin
                    next_byte = shadow[(PAY_BYTES-1-i)*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            shadow     <= '0;
            seq_frame  <= '0;
            idx        <= '0;
            chk_acc    <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            frame_busy <= 1'b0;
            frame_done <= 1'b0;
            seq_cnt    <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_req || auto_mode) begin
                        state      <= SEND;
                        shadow     <= ch_data;
                        seq_frame  <= seq_cnt;
                        idx        <= '0;
                        chk_acc    <= '0;
                        byte_data  <= HDR0;
                        byte_valid <= 1'b1;
                        frame_busy <= 1'b1;
                    end
                end
                SEND: begin
                    // byte_valid is always 1 here, so ready alone is a transfer.
                    if (byte_ready) begin
                        chk_acc <= chk_next;
                        if (idx == LAST_IDX) begin
                            state     <= CSUM;
                            byte_data <= chk_next;
                        end else begin
                            idx       <= idx_inc;
                            byte_data <= next_byte;
                        end
                    end
                end
                CSUM: begin
                    if (byte_ready) begin
                        state      <= IDLE;
                        byte_data  <= '0;
                        byte_valid <= 1'b0;
                        frame_busy <= 1'b0;
                        frame_done <= 1'b1;
                        seq_cnt    <= seq_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_meas_frame_packer.sv
module tb_meas_frame_packer;

    localparam int unsigned NC = 2;
    localparam int unsigned WB = 2;

    logic        sys_clk = 1'b0;
    logic        rst_n;
    logic [31:0] ch_data;
    logic        frame_req;
    logic        auto_mode;
    logic        byte_ready;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        frame_busy;
    logic        frame_done;
    logic [7:0]  seq_cnt;

    meas_frame_packer #(
        .NUM_CH    (NC),
        .WORD_BYTES(WB),
        .HDR0      (8'h55),
        .HDR1      (8'hAA)
    ) dut (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .ch_data   (ch_data),
        .frame_req (frame_req),
        .auto_mode (auto_mode),
        .byte_ready(byte_ready),
        .byte_data (byte_data),
        .byte_valid(byte_valid),
        .frame_busy(frame_busy),
        .frame_done(frame_done),
        .seq_cnt   (seq_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [7:0] b;
        bit         last;
    } ent_t;

    ent_t       sb[$];
    int         compared   = 0;
    int         mismatched = 0;
    logic [7:0] seq_model  = 8'h00;
    bit         done_exp   = 1'b0;
    bit         gap_prev   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame: headers, SEQ, payload MSB-first, then mod-256 sum.
    task automatic push_frame(input logic [31:0] d, input logic [7:0] s);
        logic [7:0] sum;
        logic [7:0] b;
        ent_t e;
        sum = s;
        e.last = 1'b0;
        e.b = 8'h55; sb.push_back(e);
        e.b = 8'hAA; sb.push_back(e);
        e.b = s;     sb.push_back(e);
        for (int k = 0; k < 4; k++) begin
            b = d[(3-k)*8 +: 8];
            sum = sum + b;
            e.b = b; sb.push_back(e);
        end
        e.b = sum; e.last = 1'b1; sb.push_back(e);
    endtask

    // Called at a negedge with inputs already set for the coming posedge.
    task automatic advance();
        bit last;
        last = 1'b0;
        if (rst_n && byte_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", {31'b0, byte_valid}, 32'd0);
            end else begin
                chk("byte_data", {24'b0, byte_data}, {24'b0, sb[0].b});
                if (byte_ready) begin
                    last = sb[0].last;
                    void'(sb.pop_front());
                end
            end
        end
        @(posedge sys_clk);
        if (last) seq_model = seq_model + 8'd1;
        done_exp = last;
        @(negedge sys_clk);
        chk("frame_done", {31'b0, frame_done}, {31'b0, done_exp});
        chk("seq_cnt", {24'b0, seq_cnt}, {24'b0, seq_model});
        if (done_exp) chk("gap_idle", {31'b0, byte_valid}, 32'd0);
        if (auto_mode && gap_prev) chk("auto_restart", {31'b0, byte_valid}, 32'd1);
        gap_prev = done_exp;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        seq_model = 8'h00;
        advance();
        rst_n = 1'b1;
        chk("rst_valid", {31'b0, byte_valid}, 32'd0);
        chk("rst_data", {24'b0, byte_data}, 32'd0);
        chk("rst_busy", {31'b0, frame_busy}, 32'd0);
    endtask

    task automatic start(input logic [31:0] d);
        ch_data = d;
        push_frame(d, seq_model);
        frame_req = 1'b1;
        advance();
        frame_req = 1'b0;
        chk("start_valid", {31'b0, byte_valid}, 32'd1);
        chk("start_busy", {31'b0, frame_busy}, 32'd1);
    endtask

    task automatic run_until(input int target, input int maxc);
        for (int n = 0; n < maxc; n++) begin
            if (sb.size() <= target) break;
            advance();
        end
        chk("timeout", sb.size(), target);
    endtask

    initial begin
        rst_n = 1'b0; ch_data = '0; frame_req = 1'b0; auto_mode = 1'b0; byte_ready = 1'b1;
        @(negedge sys_clk);
        do_reset();
        do_reset();
        chk("rst_seq", {24'b0, seq_cnt}, 32'd0);

        // basic frame
        start(32'h1234ABCD);
        run_until(0, 40);
        advance();
        chk("idle_data", {24'b0, byte_data}, 32'd0);
        chk("idle_valid", {31'b0, byte_valid}, 32'd0);
        chk("seq_after_one", {24'b0, seq_cnt}, 32'd1);

        // backpressure on 8'h34
        start(32'h1234ABCD);
        for (int i = 0; i < 20 && !(byte_valid && byte_data == 8'h34); i++) advance();
        chk("bp_reach", {24'b0, byte_data}, 32'h34);
        byte_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            advance();
            chk("bp_hold_valid", {31'b0, byte_valid}, 32'd1);
            chk("bp_hold_data", {24'b0, byte_data}, 32'h34);
        end
        byte_ready = 1'b1;
        run_until(0, 40);

        // snapshot: ch_data changes after HDR1 transfers; frame_req mid-frame ignored
        start(32'h1234ABCD);
        advance();
        advance();
        ch_data = 32'hFFFFFFFF;
        frame_req = 1'b1;
        advance();
        frame_req = 1'b0;
        run_until(0, 40);
        for (int i = 0; i < 3; i++) advance();
        chk("no_queued_req", {31'b0, byte_valid}, 32'd0);

        // reset mid-frame after 8'h34 transfers
        start(32'h1234ABCD);
        run_until(3, 40);
        do_reset();
        chk("abort_done", {31'b0, frame_done}, 32'd0);
        advance();
        chk("abort_seq", {24'b0, seq_cnt}, 32'd0);
        start(32'h1234ABCD);
        run_until(0, 40);

        // sequence wrap: 257 frames from a fresh reset
        do_reset();
        for (int f = 0; f < 257; f++) begin
            if (f == 255) chk("wrap_seq_ff", {24'b0, seq_cnt}, 32'hFF);
            if (f == 256) chk("wrap_seq_00", {24'b0, seq_cnt}, 32'h00);
            start(32'h1234ABCD + f);
            run_until(0, 40);
        end
        chk("wrap_final", {24'b0, seq_cnt}, 32'h01);

        // auto mode: three back-to-back frames
        do_reset();
        ch_data = 32'h0BADF00D;
        push_frame(32'h0BADF00D, 8'h00);
        push_frame(32'h0BADF00D, 8'h01);
        push_frame(32'h0BADF00D, 8'h02);
        auto_mode = 1'b1;
        advance();
        chk("auto_start", {31'b0, byte_valid}, 32'd1);
        run_until(12, 60);
        frame_req = 1'b1;
        advance();
        frame_req = 1'b0;
        run_until(6, 60);
        auto_mode = 1'b0;
        run_until(0, 60);
        for (int i = 0; i < 3; i++) advance();
        chk("auto_stopped", {31'b0, byte_valid}, 32'd0);
        chk("auto_seq", {24'b0, seq_cnt}, 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/meas_frame_packer.md
MEAS_FRAME_PACKER -- requirements
Module: meas_frame_packer

Interface
REQ-001 The module SHALL have parameter NUM_CH, default 5, giving the number of measurement channels per frame (1..16).
REQ-002 The module SHALL have parameter WORD_BYTES, default 4, giving the bytes per channel word (1..4).
REQ-003 The module SHALL have parameter HDR0, default 8'h55, giving the first header byte.
REQ-004 The module SHALL have parameter HDR1, default 8'hAA, giving the second header byte.
REQ-005 The module SHALL have port sys_clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-006 The module SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 The module SHALL have port ch_data, input, NUM_CH*WORD_BYTES*8 bits: the concatenated channel words, ch0 in the MSBs.
REQ-008 The module SHALL have port frame_req, input, 1 bit: a frame start request, sampled in IDLE.
REQ-009 The module SHALL have port auto_mode, input, 1 bit: when 1, frames restart back-to-back without a request.
REQ-010 The module SHALL have port byte_ready, input, 1 bit: the downstream serializer accepts byte_data.
REQ-011 The module SHALL have port byte_data, output, 8 bits: the current frame byte.
REQ-012 The module SHALL have port byte_valid, output, 1 bit: byte_data is valid.
REQ-013 The module SHALL have port frame_busy, output, 1 bit: a frame is in progress.
REQ-014 The module SHALL have port frame_done, output, 1 bit: a one-cycle pulse after the checksum byte transfers.
REQ-015 The module SHALL have port seq_cnt, output, 8 bits: the sequence number of the next frame to be sent.

Function
REQ-016 Frame byte order SHALL be: HDR0, HDR1, SEQ, payload, CHK.
- Payload is ch0 through ch(NUM_CH-1), each channel MSB byte first.
- Total frame length is 4+NUM_CH*WORD_BYTES bytes (24 at default parameters).
REQ-017 CHK SHALL be the 8-bit sum, modulo 256, of SEQ and all payload bytes; HDR0 and HDR1 are excluded.
REQ-018 The FSM SHALL have states IDLE, SEND and CSUM; all outputs SHALL be registered.
REQ-019 IDLE transitions to SEND when frame_req=1 or auto_mode=1. In the same edge:
- ch_data is captured into a shadow register.
- seq_cnt is captured as SEQ.
- The byte index is set to 0.
- The checksum accumulator is cleared.
REQ-020 Startup latency SHALL be one cycle: the edge that samples the start condition makes byte_valid=1, byte_data=HDR0 and frame_busy=1.
REQ-021 A transfer SHALL occur only on a cycle with byte_valid=1 and byte_ready=1; each transfer advances to the next byte.
REQ-022 While byte_valid=1 and byte_ready=0, byte_data SHALL hold stable and byte_valid SHALL stay 1.
REQ-023 When the last payload byte transfers, the FSM SHALL enter CSUM with byte_data=CHK.
REQ-024 When CHK transfers:
- frame_done pulses high for exactly the next cycle.
- seq_cnt increments, wrapping 8'hFF to 8'h00.
- frame_busy and byte_valid clear.
- The FSM returns to IDLE.
REQ-025 In IDLE with auto_mode=1, the next frame SHALL start on the edge after the frame_done cycle, so HDR0 is valid 2 cycles after the CHK transfer.
REQ-026 frame_req asserted while frame_busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-027 Changes to ch_data during a frame SHALL NOT affect that frame; the payload always comes from the shadow register.
REQ-028 In IDLE, byte_valid=0 and byte_data=8'h00.

Reset
REQ-029 When rst_n=0 at a clock edge, the module SHALL enter IDLE and set:
- byte_valid=0, byte_data=8'h00
- frame_busy=0, frame_done=0
- seq_cnt=8'h00
- byte index=0, checksum accumulator=0
REQ-030 Reset mid-frame SHALL abort the frame: no frame_done pulse and no seq_cnt increment; the next frame starts from HDR0.
REQ-031 Reset SHALL take priority over frame_req, auto_mode and byte_ready in the same cycle.

Verification
REQ-032 Basic frame: NUM_CH=2, WORD_BYTES=2, ch_data=32'h1234ABCD, byte_ready=1, one-cycle frame_req -> bytes 55 AA 00 12 34 AB CD BE on consecutive cycles, one frame_done pulse, then seq_cnt=01.
REQ-033 Backpressure: same stimulus with byte_ready=0 for 3 cycles while byte_data=8'h34 -> 8'h34 held for 4 cycles with byte_valid=1, and the frame content is unchanged.
REQ-034 Snapshot: ch_data changes to 32'hFFFFFFFF after the HDR1 transfer -> the frame still carries 12 34 AB CD and CHK=BE.
REQ-035 Sequence wrap: 257 frames -> the 256th frame carries SEQ=FF with matching CHK, and the 257th carries SEQ=00.
REQ-036 Reset mid-frame: rst_n=0 for 1 cycle after the payload byte 8'h34 -> no frame_done, seq_cnt=00, and the next frame_req yields 55 AA 00 ...
REQ-037 Auto mode: auto_mode=1, byte_ready=1 -> back-to-back frames with SEQ 00, 01, 02, and exactly one idle cycle (frame_done) between each CHK and the next HDR0; frame_req pulses mid-frame are ignored.
